pc_fetch_sequencer: RTL and testbench

Controller that owns and sequences the program counter for the single-cycle core. It issues instruction-memory fetches with a req/ack handshake and presents the fetched instruction to decode with a valid/ready handshake. It selects the next PC from exception vector, branch target or PC+4, and provides run/halt control plus a fetch-timeout fault.

---
 rtl/pc_fetch_sequencer.sv | 106 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: fetches over imem req/ack and issues to decode over valid/ready.
// Latency: at least one FETCH cycle, then one cycle to ISSUE. A fetch with no ack for too long faults to EXC_VECTOR.
// Backpressure: instr/instr_pc are held in ISSUE until instr_ready; imem_addr is held until imem_ack.
module pc_fetch_sequencer #(
    parameter int             W            = 32,
    parameter logic [W-1:0]   RESET_VECTOR = '0,
    parameter logic [W-1:0]   EXC_VECTOR   = W'(32'h0000_0100),
    parameter int             MAX_WAIT     = 15
) (
    input  logic         clk,
    input  logic         reset_asynchronous_n,
    input  logic         enable,
    input  logic         halt_req,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_rdata,
    output logic         instr_valid,
    output logic [W-1:0] instr,
    output logic [W-1:0] instr_pc,
    input  logic         instr_ready,
    input  logic         branch_taken,
    input  logic [W-1:0] branch_target,
    input  logic         exception,
    output logic         fetch_fault,
    output logic [1:0]   state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [1:0]   st;
    logic [W-1:0] pc;
    logic [7:0]   wait_cnt;
    logic [W-1:0] instr_q;
    logic [W-1:0] instr_pc_q;
    logic         fault_q;
    logic [W-1:0] retire_pc;

    // Branch targets are word-aligned; PC+4 wraps naturally at W bits.
    assign retire_pc = branch_taken ? {branch_target[W-1:2], 2'b00} : pc + W'(4);

    always_ff @(posedge clk or negedge reset_asynchronous_n) begin
        if (!reset_asynchronous_n) begin
            st         <= S_IDLE;
            pc         <= RESET_VECTOR;
            wait_cnt   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (enable) st <= S_FETCH;
                end
                S_FETCH: begin
                    // Exception outranks a same-cycle ack; ack outranks the timeout.
                    if (exception) begin
                        pc       <= EXC_VECTOR;
                        wait_cnt <= '0;
                    end else if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc;
                        wait_cnt   <= '0;
                        st         <= S_ISSUE;
                    end else if (wait_cnt == MAX_WAIT_C) begin
                        fault_q  <= 1'b1;
                        pc       <= EXC_VECTOR;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ISSUE: begin
                    if (exception) begin
                        pc       <= EXC_VECTOR;
                        wait_cnt <= '0;
                        st       <= S_FETCH;
                    end else if (instr_ready) begin
                        pc <= retire_pc;
                        if (halt_req)     st <= S_HALT;
                        else if (!enable) st <= S_IDLE;
                        else              st <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!halt_req) st <= enable ? S_FETCH : S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign state       = st;
    assign imem_req    = (st == S_FETCH);
    assign instr_valid = (st == S_ISSUE);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by a randomized run, all
// checked every cycle against a transaction-level model of the sequencer.
module tb_pc_fetch_sequencer;

    localparam int          W        = 32;
    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] EXC      = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, halt_req, imem_ack, instr_ready, branch_taken, exception;
    logic [W-1:0]  imem_rdata, branch_target;
    logic          imem_req, instr_valid, fetch_fault;
    logic [W-1:0]  imem_addr, instr, instr_pc;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer #(.W(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_asynchronous_n(rst_n),
        .enable(enable), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .branch_taken(branch_taken), .branch_target(branch_target),
        .exception(exception), .fetch_fault(fetch_fault), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: phase of the instruction lifecycle plus architectural values.
    typedef enum int {PH_IDLE = 0, PH_FETCH = 1, PH_ISSUE = 2, PH_HALT = 3} phase_t;
    phase_t       m_phase;
    logic [31:0]  m_pc, m_instr, m_ipc;
    logic         m_fault;
    int           m_unacked;   // consecutive unanswered cycles of the current fetch attempt

    task automatic model_reset();
        m_phase = PH_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
        m_fault = 1'b0; m_unacked = 0;
    endtask

    // Apply the current inputs to the model, as the next rising edge will.
    task automatic model_step();
        if (m_phase == PH_IDLE) begin
            if (enable) m_phase = PH_FETCH;
        end else if (m_phase == PH_HALT) begin
            if (!halt_req) m_phase = enable ? PH_FETCH : PH_IDLE;
        end else if (exception) begin
            m_pc = EXC; m_unacked = 0; m_phase = PH_FETCH;
        end else if (m_phase == PH_FETCH) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_ipc = m_pc; m_unacked = 0; m_phase = PH_ISSUE;
            end else begin
                m_unacked++;
                if (m_unacked > MAX_WAIT) begin
                    m_fault = 1'b1; m_pc = EXC; m_unacked = 0;
                end
            end
        end else if (instr_ready) begin
            m_pc = branch_taken ? (branch_target & 32'hFFFF_FFFC) : m_pc + 32'd4;
            if (halt_req)     m_phase = PH_HALT;
            else if (!enable) m_phase = PH_IDLE;
            else              m_phase = PH_FETCH;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, 32'(state),       32'(m_phase));
        check({tag, ".req"},   32'(imem_req),    32'(m_phase == PH_FETCH));
        check({tag, ".valid"}, 32'(instr_valid), 32'(m_phase == PH_ISSUE));
        check({tag, ".addr"},  imem_addr,        m_pc);
        check({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
        check({tag, ".instr"}, instr,            m_instr);
        check({tag, ".ipc"},   instr_pc,         m_ipc);
    endtask

    task automatic clear_inputs();
        enable = 1'b1; halt_req = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0; exception = 1'b0;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic fetch_now(input logic [31:0] data);
        imem_ack = 1'b1; imem_rdata = data;
        cycle("fetch");
        imem_ack = 1'b0;
    endtask

    task automatic retire(input logic taken, input logic [31:0] tgt);
        instr_ready = 1'b1; branch_taken = taken; branch_target = tgt;
        cycle("retire");
        instr_ready = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic fetch: ack on the second FETCH cycle
        cycle("t1_enter");
        check("t1_addr0", imem_addr, 32'h0);
        cycle("t1_wait");
        fetch_now(32'hDEADBEEF);
        check("t1_instr", instr, 32'hDEADBEEF);
        check("t1_ipc", instr_pc, 32'h0);
        retire(1'b0, 32'h0);
        check("t1_next_addr", imem_addr, 32'h4);

        // Branch redirect, sequential increment and wrap-around
        fetch_now(32'h1111_0000);
        retire(1'b1, 32'h43);
        check("t2_align40", imem_addr, 32'h40);
        fetch_now(32'h1111_0001);
        retire(1'b1, 32'h1003);
        check("t2_branch", imem_addr, 32'h1000);
        fetch_now(32'h1111_0002);
        retire(1'b1, 32'h40);
        fetch_now(32'h1111_0003);
        retire(1'b0, 32'h1003);
        check("t2_seq44", imem_addr, 32'h44);
        fetch_now(32'h1111_0004);
        retire(1'b1, 32'hFFFF_FFFF);
        check("t2_top", imem_addr, 32'hFFFF_FFFC);
        fetch_now(32'h1111_0005);
        retire(1'b0, 32'h0);
        check("t2_wrap", imem_addr, 32'h0);

        // Fetch timeout and sticky fault
        for (int i = 0; i < MAX_WAIT + 1; i++) cycle("t3_stall");
        check("t3_fault", 32'(fetch_fault), 32'h1);
        check("t3_exc_addr", imem_addr, EXC);
        check("t3_req", 32'(imem_req), 32'h1);
        fetch_now(32'h2222_0000);
        retire(1'b0, 32'h0);
        fetch_now(32'h2222_0001);
        check("t3_sticky", 32'(fetch_fault), 32'h1);

        // Exception priority in ISSUE and in FETCH
        exception = 1'b1; instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h2000;
        cycle("t4_exc_issue");
        exception = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
        check("t4_issue_pc", imem_addr, EXC);
        exception = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        cycle("t4_exc_fetch");
        exception = 1'b0; imem_ack = 1'b0;
        check("t4_valid", 32'(instr_valid), 32'h0);
        check("t4_fetch_pc", imem_addr, EXC);
        check("t4_instr_kept", instr, 32'h2222_0001);

        // Halt, resume and park in IDLE
        fetch_now(32'h3333_0000);
        retire(1'b1, 32'h8);
        fetch_now(32'h3333_0001);
        halt_req = 1'b1;
        retire(1'b0, 32'h0);
        check("t5_halt", 32'(state), 32'd3);
        check("t5_noreq", 32'(imem_req), 32'h0);
        cycle("t5_hold");
        cycle("t5_hold");
        halt_req = 1'b0;
        cycle("t5_resume");
        check("t5_addr12", imem_addr, 32'hC);
        fetch_now(32'h3333_0002);
        enable = 1'b0;
        retire(1'b0, 32'h0);
        check("t5_idle", 32'(state), 32'd0);
        cycle("t5_park");
        check("t5_pc_kept", imem_addr, 32'h10);
        enable = 1'b1;
        cycle("t5_restart");

        // Asynchronous reset pulse in the middle of ISSUE
        fetch_now(32'h4444_0000);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        #1 rst_n = 1'b1;
        cycle("t6_restart");
        check("t6_vector", imem_addr, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            enable        = ($urandom_range(0, 9) != 0);
            halt_req      = ($urandom_range(0, 9) == 0);
            imem_ack      = (n % 400 < 40) ? 1'b0 : ($urandom_range(0, 1) == 1);
            imem_rdata    = $urandom;
            instr_ready   = ($urandom_range(0, 4) < 3);
            branch_taken  = ($urandom_range(0, 2) == 0);
            branch_target = $urandom;
            exception     = ($urandom_range(0, 29) == 0);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
